// File: rtl/counter_scheduler.sv
// Round-robin arbiter sharing one interval counter among NREQ requesters.
// Each grant runs the count 0..target, then pulses done to its owner.
module counter_scheduler #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*CW-1:0] len,
    input  logic             abort,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic             busy,
    output logic             cnt_en,
    output logic [CW-1:0]    count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   target_q, target_d;
    logic [CW-1:0]   count_q, count_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;
    logic            cnt_en_q, cnt_en_d;

    logic [PW-1:0]   pick;
    logic [PW-1:0]   idx;
    logic            found;
    logic [PW-1:0]   ptr_nxt;
    logic [NREQ-1:0] pick_oh;
    logic [NREQ-1:0] owner_oh;

    // First requester at or after ptr, wrapping at NREQ
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign ptr_nxt  = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign pick_oh  = {{(NREQ-1){1'b0}}, 1'b1} << pick;
    assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        target_d = target_q;
        count_d  = count_q;
        gnt_d    = '0;
        done_d   = '0;
        busy_d   = 1'b0;
        cnt_en_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (found) begin
                    owner_d  = pick;
                    target_d = len[int'(pick)*CW +: CW];
                    state_d  = RUN;
                    gnt_d    = pick_oh;
                    busy_d   = 1'b1;
                    cnt_en_d = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                    ptr_d   = ptr_nxt;
                end else if (count_q == target_q) begin
                    state_d = DONE;
                    gnt_d   = owner_oh;
                    done_d  = owner_oh;
                    busy_d  = 1'b1;
                end else begin
                    count_d  = count_q + 1'b1;
                    gnt_d    = owner_oh;
                    busy_d   = 1'b1;
                    cnt_en_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                count_d = '0;
                ptr_d   = ptr_nxt;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            target_q <= '0;
            count_q  <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            cnt_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            target_q <= target_d;
            count_q  <= count_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            cnt_en_q <= cnt_en_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign cnt_en = cnt_en_q;
    assign count  = count_q;

endmodule

// File: doc/counter_scheduler.md
# counter_scheduler

- Round-robin scheduler that shares one internal mod-2^CW interval counter among NREQ requesters.
- Each requester asks for a timed interval of its own length. The block grants the counter to one requester at a time, runs the count to completion, and signals completion with a one-cycle pulse.
- It sits between requesting blocks and the shared counting resource, and replaces per-requester counters.

## Interface

- NREQ, 4, number of requesters; supported range 2..8.
- CW, 4, counter width; intervals range 0..2^CW-1.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request per requester; held until its done pulse.
- len  in  NREQ*CW  packed interval targets; requester i uses bits [i*CW +: CW]; sampled only in the grant-decision cycle.
- abort  in  1  synchronous cancel of the current run.
- gnt  out  NREQ  one-hot owner of the counter; all zero when idle.
- done  out  NREQ  one-cycle completion pulse to the owner.
- busy  out  1  high whenever state is not IDLE.
- cnt_en  out  1  high while the counter is advancing (state RUN).
- count  out  CW  current counter value.

## Operation

**States: IDLE, RUN, DONE.** All outputs are registered.

**Reset (reset=0)**
- State goes to IDLE.
- gnt=0, done=0, busy=0, cnt_en=0, count=0.
- Round-robin pointer ptr=0, target=0, owner=0.
- Takes effect immediately, including mid-run. No done pulse is issued for a run killed by reset.

**IDLE**
- If any req bit is set, search indices ptr, ptr+1, ... mod NREQ. The first set bit wins and becomes owner.
- Latch target=len[owner]. Clear count to 0. Next state RUN.
- If no req bit is set, stay in IDLE with count=0.

**RUN**
- gnt[owner]=1, cnt_en=1.
- count increments by 1 each cycle, starting at 0.
- When count==target and abort=0: next state DONE. count holds target.
- The count never wraps, because target ≤ 2^CW-1.
- target=0 gives exactly one RUN cycle.

**DONE**
- gnt[owner]=1, done[owner]=1, cnt_en=0, count=target.
- Next state IDLE, count cleared to 0, ptr=(owner+1) mod NREQ.

**abort**
- Honoured only in RUN: next state IDLE, gnt=0, count=0, ptr=(owner+1) mod NREQ, no done pulse.
- If abort is asserted in the same cycle that count==target, abort wins and no done pulse is issued.
- Ignored in IDLE and DONE.

**Other behaviour**
- Changes to req or len for the owner during RUN or DONE are ignored. The run completes with the latched target.
- A requester that still holds req in the IDLE cycle after its own DONE is treated as a new request, but at lowest priority, because ptr has advanced past it.
- Requesters with req=0 are never granted.

## Timing

- req→gnt latency: 1 cycle from IDLE. The decision is made in IDLE, and gnt rises on the next edge.
- Grant duration: gnt high for target+2 cycles (target+1 RUN cycles plus 1 DONE cycle).
- done: asserted exactly 1 cycle, coincident with the last gnt cycle.
- Back-to-back requesters: exactly one IDLE cycle between consecutive grants. Total occupancy per grant is target+3 cycles.
- After abort: IDLE on the next edge. The next grant follows one cycle later at the earliest.
- Reset: asynchronous assertion clears all outputs without waiting for a clock edge. Release is sampled on clk.

## Test plan

1. **Reset mid-run.** req[1]=1, len1=9; drive reset=0 when count=4.
   - Required: gnt, done, busy, cnt_en and count all go to 0 immediately.
   - After reset=1 with req[1] still high: gnt=0010 again two edges later, count restarting at 0.
2. **Single requester, NREQ=4, CW=4.** req[2]=1, len2=3.
   - Required: gnt=0100 one cycle after req; count 0,1,2,3 over 4 RUN cycles.
   - Then done=0100 for 1 cycle with count=3, then gnt=0, busy=0, count=0.
3. **Round robin.** req=1111 held, all len=0.
   - Required: grant order 0,1,2,3,0,...
   - Each gnt lasts 2 cycles, with done on the second cycle and one idle cycle between grants.
4. **Maximum interval.** req[0]=1, len0=15.
   - Required: 16 RUN cycles with count 0..15, no wrap to 0 before DONE.
   - done[0] fires with count=15.
5. **Abort.** req=0011, len0=10; assert abort when count=2.
   - Required: next cycle state IDLE, gnt=0, no done pulse.
   - The following grant goes to requester 1.
6. **Abort on the terminal cycle.** len=5; assert abort when count=5.
   - Required: no done pulse; IDLE next; ptr advanced to owner+1.
